decoder_pipe: RTL and testbench
===============================

DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 The block SHALL have parameter N, default 3: input code width; output width is 2**N.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1: upstream holds a code.
REQ-006 The block SHALL have port in_ready, output, 1: block can accept a code this cycle.
REQ-007 The block SHALL have port in_code, input, N: binary code to decode.
REQ-008 The block SHALL have port in_par, input, 1: even-parity bit over in_code.
REQ-009 The block SHALL have port out_valid, output, 1: out_onehot/out_err hold a decoded entry.
REQ-010 The block SHALL have port out_ready, input, 1: downstream accepts the entry this cycle.
REQ-011 The block SHALL have port out_onehot, output, 2**N: one-hot decoded value.
REQ-012 The block SHALL have port out_err, output, 1: parity error on this entry.
REQ-013 The block SHALL have port dec_count, output, CNT_W: good entries delivered.
REQ-014 The block SHALL have port err_count, output, CNT_W: errored entries delivered.

Function
REQ-015 The input handshake SHALL complete ("push") on a rising edge where in_valid=1 and in_ready=1; the output handshake SHALL complete ("pop") on a rising edge where out_valid=1 and out_ready=1.
REQ-016 Decoded entries SHALL be buffered in a 2-entry FIFO; occupancy 0, 1 or 2; delivery strictly in push order.
REQ-017 in_ready SHALL be 1 exactly when rst=0 and registered occupancy < 2; it SHALL NOT depend combinationally on out_ready or in_valid.
REQ-018 An entry pushed with parity OK (XOR of in_code and in_par = 0) SHALL store out_onehot = 1 << in_code and out_err = 0.
REQ-019 An entry pushed with parity failure SHALL store out_onehot = all zeros and out_err = 1.
REQ-020 Latency: a push into an empty FIFO at edge k SHALL give out_valid=1 with that entry from edge k (visible cycle after push); no combinational input-to-output path.
REQ-021 out_valid SHALL equal (occupancy > 0); out_onehot and out_err SHALL show the head entry and be all zeros when occupancy = 0.
REQ-022 While out_valid=1 and out_ready=0, out_onehot and out_err SHALL hold stable.
REQ-023 Simultaneous push and pop at occupancy 1 SHALL leave occupancy 1, the new entry becoming head.
REQ-024 At occupancy 2 no push SHALL occur (in_ready=0); a pop SHALL drop occupancy to 1 and raise in_ready from the next cycle.
REQ-025 A pop with out_err=0 SHALL increment dec_count; a pop with out_err=1 SHALL increment err_count; both counters SHALL saturate at 2**CNT_W-1 (no wrap).
REQ-026 in_valid, in_code and in_par SHALL be ignored when in_ready=0; out_ready SHALL be ignored when out_valid=0.

Reset
REQ-027 On a rising edge with rst=1: occupancy 0, out_valid 0, out_onehot 0, out_err 0, dec_count 0, err_count 0.
REQ-028 in_ready SHALL be 0 during any cycle with rst=1 and 1 on the first cycle after rst deasserts.
REQ-029 Reset mid-operation SHALL discard buffered entries without popping them; counters SHALL not increment on that edge.

Verification
REQ-030 Single decode: N=3, push code 3'b101 par 0, out_ready=1 -> next cycle out_valid=1, out_onehot=8'b0010_0000, out_err=0; after pop dec_count=1.
REQ-031 Parity error: push code 3'b011 par 1 -> out_onehot=8'h00, out_err=1; after pop err_count=1, dec_count unchanged.
REQ-032 Backpressure: out_ready=0, push codes 0,7,4 on consecutive cycles -> only 0 and 7 accepted, in_ready=0 after second push, out_onehot held at 8'h01; raise out_ready -> 8'h01 then 8'h80 in order.
REQ-033 Streaming: in_valid=1, out_ready=1 for 20 cycles with codes 0..7 repeating -> one entry per cycle, occupancy stays 1, dec_count=20.
REQ-034 Reset mid-operation: occupancy 2, assert rst one cycle -> out_valid=0, out_onehot=0, counters 0, in_ready=0 that cycle and 1 next cycle.
REQ-035 Saturation: CNT_W=2, deliver 5 good entries -> dec_count reaches 3 and stays 3.

Source files
------------

// File: rtl/decoder_pipe.sv
// Parity-checked binary-to-one-hot decoder feeding a 2-entry output FIFO,
// with saturating counters of delivered good and errored entries.
module decoder_pipe #(
    parameter int N     = 3,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_code,
    input  logic              in_par,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2**N-1:0]   out_onehot,
    output logic              out_err,
    output logic [CNT_W-1:0]  dec_count,
    output logic [CNT_W-1:0]  err_count
);
    localparam int W = 2**N;

    typedef struct packed {
        logic         err;
        logic [W-1:0] oh;
    } entry_t;

    entry_t             e0_q, e0_d, e1_q, e1_d, new_e;
    logic [1:0]         occ_q, occ_d, wr_lvl;
    logic [CNT_W-1:0]   dec_q, dec_d, err_q, err_d;
    logic               push, pop, par_ok;

    assign in_ready   = !rst && (occ_q != 2'd2);
    assign out_valid  = (occ_q != 2'd0);
    assign out_onehot = e0_q.oh;
    assign out_err    = e0_q.err;
    assign dec_count  = dec_q;
    assign err_count  = err_q;

    assign push   = in_valid && in_ready;
    assign pop    = out_valid && out_ready;
    assign par_ok = ~(^in_code ^ in_par);

    always_comb begin
        new_e.err = ~par_ok;
        new_e.oh  = par_ok ? ({{(W-1){1'b0}}, 1'b1} << in_code) : '0;
    end

    // Unused slots are kept at zero so the head reads all zeros when empty.
    always_comb begin
        e0_d   = e0_q;
        e1_d   = e1_q;
        dec_d  = dec_q;
        err_d  = err_q;
        wr_lvl = occ_q - {1'b0, pop};
        occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
        if (pop) begin
            e0_d = e1_q;
            e1_d = '0;
            if (e0_q.err) begin
                if (err_q != '1) err_d = err_q + 1'b1;
            end else begin
                if (dec_q != '1) dec_d = dec_q + 1'b1;
            end
        end
        if (push) begin
            if (wr_lvl == 2'd0) e0_d = new_e;
            else                e1_d = new_e;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
            dec_q <= '0;
            err_q <= '0;
        end else begin
            occ_q <= occ_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            dec_q <= dec_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_decoder_pipe.sv
// Randomized and directed stimulus against a queue-based reference model;
// a negedge monitor compares every presented entry and the counters.
module tb_decoder_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  in_code = '0;
    logic        in_par = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_err;
    logic [7:0]  out_onehot;
    logic [15:0] dec_count, err_count;
    logic        s_in_ready, s_out_valid, s_out_err;
    logic [7:0]  s_out_onehot;
    logic [1:0]  s_dec_count, s_err_count;

    always #5 clk = ~clk;

    decoder_pipe #(.N(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_par(in_par), .out_valid(out_valid),
        .out_ready(out_ready), .out_onehot(out_onehot), .out_err(out_err),
        .dec_count(dec_count), .err_count(err_count));

    decoder_pipe #(.N(3), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_code(in_code), .in_par(in_par), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_onehot(s_out_onehot), .out_err(s_out_err),
        .dec_count(s_dec_count), .err_count(s_err_count));

    typedef struct {
        logic       err;
        logic [7:0] oh;
    } exp_t;

    exp_t sbq[$];
    exp_t pend;
    bit   pend_v = 0;
    int   n_cmp = 0, n_bad = 0;
    int   dec_m = 0, err_m = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] c, input logic p);
        exp_t e;
        e.oh = 8'h00;
        e.err = ($countones({c, p}) % 2) != 0;
        if (!e.err) e.oh[c] = 1'b1;
        return e;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // One clock cycle of stimulus; the expected entry is issued to the scoreboard.
    task automatic cyc(input logic v, input logic [2:0] c, input logic p,
                       input logic o, input logic r);
        logic exp_rdy;
        @(posedge clk);
        #1;
        rst = r; in_valid = v; in_code = c; in_par = p; out_ready = o;
        #1;
        exp_rdy = !r && (sbq.size() < 2);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        if (v && exp_rdy) begin
            pend   = mk(c, p);
            pend_v = 1;
        end
    endtask

    // Monitor: outputs here are what the next rising edge will see.
    always @(negedge clk) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, sbq.size() > 0});
        if (sbq.size() > 0) begin
            chk("out_onehot", {24'd0, out_onehot}, {24'd0, sbq[0].oh});
            chk("out_err", {31'd0, out_err}, {31'd0, sbq[0].err});
        end else begin
            chk("empty_onehot", {24'd0, out_onehot}, 32'd0);
            chk("empty_err", {31'd0, out_err}, 32'd0);
        end
        chk("dec_count", {16'd0, dec_count}, dec_m);
        chk("err_count", {16'd0, err_count}, err_m);
        chk("sat_dec_count", {30'd0, s_dec_count}, sat3(dec_m));
        chk("sat_err_count", {30'd0, s_err_count}, sat3(err_m));
        if (rst) begin
            sbq.delete();
            dec_m = 0;
            err_m = 0;
        end else if (sbq.size() > 0 && out_ready) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.err) err_m++;
            else       dec_m++;
        end
    end

    always @(negedge clk) begin
        #1;
        if (pend_v) begin
            sbq.push_back(pend);
            pend_v = 0;
        end
    end

    initial begin
        logic [2:0] c;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        // single good decode, then a parity error
        cyc(1, 3'b101, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 3'b011, 1, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        // backpressure: third push refused
        cyc(1, 3'd0, 0, 0, 0);
        cyc(1, 3'd7, 1, 0, 0);
        cyc(1, 3'd4, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        // streaming
        for (int i = 0; i < 20; i++) begin
            c = 3'(i);
            cyc(1, c, ^c, 1, 0);
        end
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        // reset while full
        cyc(1, 3'd2, 1, 0, 0);
        cyc(1, 3'd6, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 3'd1, 1, 1, 1);
        cyc(0, 0, 0, 1, 0);
        // saturation of the narrow counters
        for (int i = 0; i < 5; i++) begin
            c = 3'(i + 1);
            cyc(1, c, ^c, 1, 0);
        end
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        // random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            logic v, o, r, p;
            c = 3'($urandom_range(0, 7));
            v = ($urandom_range(0, 3) != 0);
            o = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 60) == 0);
            p = ($urandom_range(0, 3) == 0) ? ~(^c) : ^c;
            cyc(v, c, p, o, r);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
